// File: rtl/alu_issue_if.sv
// ---------------------------------------------------------------------------
// alu_issue_if
// Purpose : bundles every handshake and bus signal of the alu_issue block
//           (instruction input, ALU drive/return, writeback and flags) so the
//           issue stage and its environment connect through a single port.
// Signals :
//   in_valid / in_ready          instruction handshake
//   in_opcode, in_rd, in_rs1,    instruction fields
//   in_rs2, in_imm_sel, in_imm
//   opcode, src_a, src_b         operation and operands driven to the ALU
//   alu_out, zero, overflow      ALU result and flags
//   wb_valid, wb_rd, wb_data     writeback event
//   flag_zero, flag_ovf          status flags, clr_flags clears flag_ovf
// Modports:
//   master - environment side (instruction source + ALU + flag control)
//   slave  - alu_issue side
// ---------------------------------------------------------------------------
interface alu_issue_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic [2:0] in_rd;
    logic [2:0] in_rs1;
    logic [2:0] in_rs2;
    logic       in_imm_sel;
    logic [3:0] in_imm;
    logic [2:0] opcode;
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] alu_out;
    logic       zero;
    logic       overflow;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [3:0] wb_data;
    logic       flag_zero;
    logic       flag_ovf;
    logic       clr_flags;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm_sel, in_imm,
               alu_out, zero, overflow, clr_flags,
        input  in_ready, opcode, src_a, src_b, wb_valid, wb_rd, wb_data,
               flag_zero, flag_ovf
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm_sel, in_imm,
               alu_out, zero, overflow, clr_flags,
        output in_ready, opcode, src_a, src_b, wb_valid, wb_rd, wb_data,
               flag_zero, flag_ovf
    );
endinterface

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
// Purpose : single-issue front end for an external 4-bit ALU. It owns an
//           8 x 4-bit register file (r0 hardwired to zero), reads operands
//           when an instruction is accepted, drives the ALU from issue
//           registers for one cycle and writes the result back, raising
//           wb_valid two cycles after the accept.
// Ports   :
//   clk      clock
//   reset    synchronous, active-high reset
//   bus      alu_issue_if.slave (instruction handshake, ALU drive/return,
//            writeback, flags)
// Config  :
//   ALU_ISSUE_BYPASS_EN  defined   -> a read of the register being produced
//                                     by the instruction in the issue stage
//                                     takes alu_out directly; no stall.
//                        undefined -> such a read stalls in_ready for one
//                                     cycle until the writeback lands.
//   Results are identical in both builds; only timing differs.
// ---------------------------------------------------------------------------
module alu_issue (
    input  logic       clk,
    input  logic       reset,
    alu_issue_if.slave bus
);

    logic [3:0] regFile_q [8];

    logic       issueValid_q, issueValid_d;
    logic [2:0] issueOpcode_q, issueOpcode_d;
    logic [3:0] srcA_q, srcA_d;
    logic [3:0] srcB_q, srcB_d;
    logic [2:0] issueRd_q, issueRd_d;

    logic       wbValid_q;
    logic [2:0] wbRd_q;
    logic [3:0] wbData_q;
    logic       flagZero_q;
    logic       flagOvf_q;

    logic [3:0] rs1Val;
    logic [3:0] rs2Val;
    logic [3:0] operandA;
    logic [3:0] operandB;
    logic       hazardA;
    logic       hazardB;
    logic       inReady;
    logic       accept;

    // Plain register-file reads. r0 is forced to zero here as well so the
    // read path never depends on what the storage for entry 0 holds.
    always_comb begin
        rs1Val = (bus.in_rs1 == 3'd0) ? 4'd0 : regFile_q[bus.in_rs1];
        rs2Val = (bus.in_rs2 == 3'd0) ? 4'd0 : regFile_q[bus.in_rs2];
    end

    // The instruction sitting in the issue stage only reaches the register
    // file at the end of this cycle, so a source that names its destination
    // would read a stale value. rs2 is irrelevant when the immediate is used,
    // and r0 is never a real destination.
    always_comb begin
        hazardA = issueValid_q && (issueRd_q != 3'd0) && (bus.in_rs1 == issueRd_q);
        hazardB = issueValid_q && (issueRd_q != 3'd0) && !bus.in_imm_sel
                  && (bus.in_rs2 == issueRd_q);
    end

    // Operand selection and acceptance. With bypass the in-flight result is
    // forwarded straight from the ALU; without it the input is held off for
    // one cycle, after which the register file already has the value.
    always_comb begin
`ifdef ALU_ISSUE_BYPASS_EN
        operandA = hazardA ? bus.alu_out : rs1Val;
        operandB = bus.in_imm_sel ? bus.in_imm : (hazardB ? bus.alu_out : rs2Val);
        inReady  = !reset;
`else
        operandA = rs1Val;
        operandB = bus.in_imm_sel ? bus.in_imm : rs2Val;
        inReady  = !reset && !(hazardA || hazardB);
`endif
        accept = bus.in_valid && inReady;
    end

    // Next state of the issue registers. The ALU drive holds its last
    // operands when nothing is accepted; only the valid bit drops.
    always_comb begin
        issueValid_d  = accept;
        issueOpcode_d = issueOpcode_q;
        srcA_d        = srcA_q;
        srcB_d        = srcB_q;
        issueRd_d     = issueRd_q;
        if (accept) begin
            issueOpcode_d = bus.in_opcode;
            srcA_d        = operandA;
            srcB_d        = operandB;
            issueRd_d     = bus.in_rd;
        end
    end

    // Issue stage registers; reset drops any accepted instruction so it
    // never reaches writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            issueValid_q  <= 1'b0;
            issueOpcode_q <= 3'd0;
            srcA_q        <= 4'd0;
            srcB_q        <= 4'd0;
            issueRd_q     <= 3'd0;
        end else begin
            issueValid_q  <= issueValid_d;
            issueOpcode_q <= issueOpcode_d;
            srcA_q        <= srcA_d;
            srcB_q        <= srcB_d;
            issueRd_q     <= issueRd_d;
        end
    end

    // Register file write at the end of the issue cycle; writes to r0 are
    // dropped so it stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regFile_q[i] <= 4'd0;
            end
        end else if (issueValid_q && (issueRd_q != 3'd0)) begin
            regFile_q[issueRd_q] <= bus.alu_out;
        end
    end

    // Writeback report and flags. wb_valid pulses for every instruction,
    // including those targeting r0. The overflow flag is sticky; a new
    // overflow in the same cycle as a clear takes priority so it is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            wbValid_q  <= 1'b0;
            wbRd_q     <= 3'd0;
            wbData_q   <= 4'd0;
            flagZero_q <= 1'b0;
            flagOvf_q  <= 1'b0;
        end else begin
            wbValid_q <= issueValid_q;
            if (issueValid_q) begin
                wbRd_q     <= issueRd_q;
                wbData_q   <= bus.alu_out;
                flagZero_q <= bus.zero;
            end
            if (issueValid_q && bus.overflow) begin
                flagOvf_q <= 1'b1;
            end else if (bus.clr_flags) begin
                flagOvf_q <= 1'b0;
            end
        end
    end

    // Output drive
    assign bus.in_ready  = inReady;
    assign bus.opcode    = issueOpcode_q;
    assign bus.src_a     = srcA_q;
    assign bus.src_b     = srcB_q;
    assign bus.wb_valid  = wbValid_q;
    assign bus.wb_rd     = wbRd_q;
    assign bus.wb_data   = wbData_q;
    assign bus.flag_zero = flagZero_q;
    assign bus.flag_ovf  = flagOvf_q;

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue
// Purpose : self-checking bench for alu_issue. Provides a combinational ALU
//           model, drives instructions through the handshake, and keeps a
//           reference register file. Each accepted instruction pushes its
//           expected writeback into a queue; the writeback monitor pops and
//           compares it (rd, data, zero flag, accept-to-writeback latency).
// ---------------------------------------------------------------------------
module tb_alu_issue;

    logic clk;
    logic reset;

    alu_issue_if bus ();

    alu_issue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] rd;
        logic [3:0] data;
        logic       zero;
        int         cyc;
    } wbExp_t;

    wbExp_t     sbQ[$];
    wbExp_t     monEntry;
    logic [3:0] refRf [8];
    int         checkCount;
    int         errorCount;
    int         cycle;
    logic [4:0] aluRes;

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle counter used for latency checks
    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Reference ALU: 000 and, 001 or, 010 xor, 011 pass b, 100 add,
    // 101 sub, others pass a. Overflow is signed overflow for add/sub.
    function automatic logic [4:0] aluFn(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
        logic [3:0] r;
        logic       v;
        v = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: r = a ^ b;
            3'b011: r = b;
            3'b100: begin
                r = a + b;
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            3'b101: begin
                r = a - b;
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            default: r = a;
        endcase
        return {v, r};
    endfunction

    // External ALU seen by the DUT
    always_comb begin
        aluRes       = aluFn(bus.opcode, bus.src_a, bus.src_b);
        bus.alu_out  = aluRes[3:0];
        bus.overflow = aluRes[4];
        bus.zero     = (aluRes[3:0] == 4'd0);
    end

    // Single comparison point
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Writeback monitor: every wb_valid pulse must match the oldest
    // outstanding instruction, exactly two cycles after its accept.
    always @(negedge clk) begin
        if (bus.wb_valid === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedWb", 32'd1, 32'd0);
            end else begin
                monEntry = sbQ.pop_front();
                checkOutput("wbRd", 32'(bus.wb_rd), 32'(monEntry.rd));
                checkOutput("wbData", 32'(bus.wb_data), 32'(monEntry.data));
                checkOutput("flagZero", 32'(bus.flag_zero), 32'(monEntry.zero));
                checkOutput("wbLatency", 32'(cycle), 32'(monEntry.cyc + 2));
            end
        end
    end

    task automatic idleCycles(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset for two cycles; outputs are checked while reset is still high.
    task automatic resetDut();
        bus.in_valid  = 1'b0;
        bus.clr_flags = 1'b0;
        reset         = 1'b1;
        sbQ.delete();
        for (int i = 0; i < 8; i++) refRf[i] = 4'd0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstInReady", 32'(bus.in_ready), 32'd0);
        checkOutput("rstWbValid", 32'(bus.wb_valid), 32'd0);
        checkOutput("rstWbRd", 32'(bus.wb_rd), 32'd0);
        checkOutput("rstWbData", 32'(bus.wb_data), 32'd0);
        checkOutput("rstSrcA", 32'(bus.src_a), 32'd0);
        checkOutput("rstSrcB", 32'(bus.src_b), 32'd0);
        checkOutput("rstOpcode", 32'(bus.opcode), 32'd0);
        checkOutput("rstFlagZero", 32'(bus.flag_zero), 32'd0);
        checkOutput("rstFlagOvf", 32'(bus.flag_ovf), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Offer one instruction and wait (bounded) for it to be accepted.
    // On accept the reference model is updated and the writeback expected.
    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rd,
                                 input logic [2:0] rs1, input logic [2:0] rs2,
                                 input logic immSel, input logic [3:0] imm,
                                 output int stalls);
        logic       accepted;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] r;
        wbExp_t     e;
        bus.in_valid   = 1'b1;
        bus.in_opcode  = op;
        bus.in_rd      = rd;
        bus.in_rs1     = rs1;
        bus.in_rs2     = rs2;
        bus.in_imm_sel = immSel;
        bus.in_imm     = imm;
        stalls   = 0;
        accepted = 1'b0;
        while (!accepted && stalls <= 8) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                accepted = 1'b1;
            end else begin
                stalls++;
                @(posedge clk);
                #1;
            end
        end
        if (!accepted) begin
            checkOutput("acceptTimeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        a = refRf[rs1];
        b = immSel ? imm : refRf[rs2];
        r = aluFn(op, a, b);
        if (rd != 3'd0) refRf[rd] = r[3:0];
        e.rd   = rd;
        e.data = r[3:0];
        e.zero = (r[3:0] == 4'd0);
        e.cyc  = cycle;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pulseClear();
        bus.clr_flags = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_flags = 1'b0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stalls;
        int expStall;
        checkCount     = 0;
        errorCount     = 0;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_opcode  = 3'd0;
        bus.in_rd      = 3'd0;
        bus.in_rs1     = 3'd0;
        bus.in_rs2     = 3'd0;
        bus.in_imm_sel = 1'b0;
        bus.in_imm     = 4'd0;
        bus.clr_flags  = 1'b0;
`ifdef ALU_ISSUE_BYPASS_EN
        expStall = 0;
`else
        expStall = 1;
`endif

        resetDut();

        // r1 <= 3, r2 <= 5, r3 <= r1 + r2 = 8
        applyStimulus(3'b011, 3'd1, 3'd0, 3'd0, 1'b1, 4'd3, stalls);
        applyStimulus(3'b011, 3'd2, 3'd0, 3'd0, 1'b1, 4'd5, stalls);
        applyStimulus(3'b100, 3'd3, 3'd1, 3'd2, 1'b0, 4'd0, stalls);
        idleCycles(4);

        // Back-to-back dependency: r1 <= 7, r2 <= r1 + r1 = 14
        applyStimulus(3'b011, 3'd1, 3'd0, 3'd0, 1'b1, 4'd7, stalls);
        applyStimulus(3'b100, 3'd2, 3'd1, 3'd1, 1'b0, 4'd0, stalls);
        checkOutput("hazardStalls", 32'(stalls), 32'(expStall));
        idleCycles(3);
        @(negedge clk);
        checkOutput("ovfAfter7plus7", 32'(bus.flag_ovf), 32'd1);
        @(posedge clk);
        #1;
        pulseClear();
        @(negedge clk);
        checkOutput("ovfClearAlone1", 32'(bus.flag_ovf), 32'd0);
        @(posedge clk);
        #1;

        // Sticky overflow: 7 + 1
        applyStimulus(3'b011, 3'd5, 3'd0, 3'd0, 1'b1, 4'd1, stalls);
        applyStimulus(3'b100, 3'd6, 3'd1, 3'd5, 1'b0, 4'd0, stalls);
        idleCycles(3);
        @(negedge clk);
        checkOutput("ovfSet", 32'(bus.flag_ovf), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(3'b011, 3'd7, 3'd0, 3'd0, 1'b1, 4'd2, stalls);
        applyStimulus(3'b001, 3'd4, 3'd5, 3'd7, 1'b0, 4'd0, stalls);
        idleCycles(3);
        @(negedge clk);
        checkOutput("ovfSticky", 32'(bus.flag_ovf), 32'd1);
        @(posedge clk);
        #1;
        // Clear while another overflow is in the issue stage: set wins
        applyStimulus(3'b100, 3'd6, 3'd1, 3'd5, 1'b0, 4'd0, stalls);
        pulseClear();
        @(negedge clk);
        checkOutput("ovfSetWins", 32'(bus.flag_ovf), 32'd1);
        @(posedge clk);
        #1;
        pulseClear();
        @(negedge clk);
        checkOutput("ovfClearAlone2", 32'(bus.flag_ovf), 32'd0);
        @(posedge clk);
        #1;
        idleCycles(2);

        // r0 stays zero: write 9 to r0, then read it back through two paths
        applyStimulus(3'b011, 3'd0, 3'd0, 3'd0, 1'b1, 4'd9, stalls);
        applyStimulus(3'b011, 3'd4, 3'd0, 3'd0, 1'b0, 4'd0, stalls);
        applyStimulus(3'b100, 3'd5, 3'd0, 3'd0, 1'b0, 4'd0, stalls);
        idleCycles(4);

        // Reset right after an accept discards the instruction
        applyStimulus(3'b100, 3'd3, 3'd1, 3'd2, 1'b0, 4'd0, stalls);
        resetDut();
        idleCycles(4);
        applyStimulus(3'b100, 3'd4, 3'd3, 3'd0, 1'b0, 4'd0, stalls);
        applyStimulus(3'b011, 3'd6, 3'd0, 3'd1, 1'b0, 4'd0, stalls);
        idleCycles(4);

        // Random traffic with occasional gaps
        for (int n = 0; n < 40; n++) begin
            applyStimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), stalls);
            if ($urandom_range(0, 3) == 0) idleCycles(1);
        end
        idleCycles(5);
        checkOutput("sbEmpty", 32'(sbQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
